tree_adder_ctrl: RTL and testbench
==================================

Name: tree_adder_ctrl

Overview:
- Sequencer and flow controller for the 256-input, 8-stage pipelined signed tree adder. Upstream drives the 16x16 operand array directly into the adder; this block does the rest:
  - generates the adder's global enable;
  - carries valid, tag and last flags alongside the adder's pipeline registers;
  - applies valid/ready back-pressure;
  - tracks the minimum sum and its tag over each group of candidates (block-match search).

Parameters:
- LATENCY, 8, adder pipeline depth in enabled clock edges; must equal the adder stage count.
- SUM_W, 17, width of the adder sum (input width + 8), signed.
- TAG_W, 8, width of the candidate tag carried with each operand set.

Ports:
- clk  in  1  clock.
- rst_n  in  1  asynchronous, active-low reset; shared with the tree adder.
- in_valid  in  1  upstream operand array and tag are valid this cycle.
- in_ready  out  1  block accepts this cycle; equals adder_enable.
- in_tag  in  TAG_W  candidate identifier.
- in_last  in  1  final candidate of the current group.
- adder_enable  out  1  enable to every adder pipeline register.
- adder_sum  in  SUM_W  final-stage registered sum from the adder.
- out_valid  out  1  out_sum/out_tag valid.
- out_ready  in  1  downstream accepts.
- out_sum  out  SUM_W  equals adder_sum.
- out_tag  out  TAG_W  tag aligned with out_sum.
- out_last  out  1  last flag aligned with out_sum.
- best_valid  out  1  one-cycle pulse: group minimum available.
- best_sum  out  SUM_W  group minimum sum.
- best_tag  out  TAG_W  tag of group minimum.
- busy  out  1  any valid entry in flight.

Behaviour:
- Reset (async, rst_n low):
  - all valid bits, tag/last shift registers, best_sum, best_tag and the state machine clear to 0 / IDLE;
  - in_ready and adder_enable are 1 once the pipeline is empty;
  - out_valid, best_valid and busy are 0.
  - Reset mid-operation discards all in-flight entries with no output; the adder clears via the same rst_n.
- Pipeline control:
  - stall = vld[LATENCY-1] & ~out_ready.
  - adder_enable = in_ready = ~stall (combinational).
- Shift on every enabled edge:
  - vld[0] <= in_valid; tag[0] <= in_tag; last[0] <= in_last.
  - Stage k <= stage k-1.
  - An enabled edge with in_valid=0 inserts a bubble (vld=0). Bubbles occupy slots; they are not squeezed out.
  - While stalled, all stages hold.
- Latency:
  - Accepting edge is E (in_valid & in_ready).
  - out_valid rises after the LATENCY-th enabled edge counting E: 8 cycles with no stalls.
  - Each stall cycle adds one.
- Outputs:
  - out_valid = vld[LATENCY-1]; out_tag/out_last from stage LATENCY-1.
  - out_sum passes adder_sum through.
  - An output handshake is out_valid & out_ready.
  - Throughput: 1 per cycle when out_ready=1.
- Group minimum FSM, states IDLE, ACCUM, DONE:
  - IDLE/DONE on handshake:
    - best <= (out_sum, out_tag);
    - if out_last go DONE, else go ACCUM.
  - ACCUM on handshake:
    - if out_sum < best_sum (signed, strict) then best <= (out_sum, out_tag);
    - ties keep the earlier candidate;
    - if out_last go DONE.
  - DONE without handshake goes to IDLE.
  - best_valid = 1 only in DONE.
  - best_sum/best_tag are held stable until the next group's first handshake overwrites them.
  - Back-to-back groups: a handshake in DONE starts the new group the same edge; best_valid lasts exactly one cycle per group.
  - A single-candidate group (in_last=1 on the first candidate) reports that candidate.
- busy = OR of all vld bits.
- Sum width: no saturation; SUM_W is sized so that 256 signed inputs cannot overflow.

Optional Feature:
- Macro TREE_CTRL_PERF_EN.
- When defined, adds outputs:
  - perf_stall_cnt [31:0]: +1 each cycle stall=1;
  - perf_bubble_cnt [31:0]: +1 each enabled edge with in_valid=0 while busy=1;
  - perf_group_cnt [15:0]: +1 per best_valid pulse.
  - All counters reset to 0 and wrap on overflow.
- When undefined, none of these ports or counters exist and behaviour is otherwise identical.

Test Plan:
- Reset release with idle inputs -> in_ready=1, out_valid=0, busy=0, best_valid=0 for 20 cycles.
- One candidate, all operands 1, tag 0x05, last=1, out_ready=1 -> out_valid exactly 8 cycles later with out_sum=256, out_tag=0x05; best_valid pulses 1 cycle, best_sum=256, best_tag=0x05.
- Group of 4, all operands equal per candidate: 3, -2, -2, 7 (sums 768, -512, -512, 1792), tags 0..3, back-to-back -> outputs on 4 consecutive cycles; best_sum=-512, best_tag=1 (tie keeps the earlier candidate); single best_valid pulse.
- out_ready low for 5 cycles while out_valid=1 with 8 entries in flight -> in_ready=0 and outputs held for those 5 cycles; no loss or duplication; order preserved on release.
- Two groups back-to-back with last on tags 3 and 7 -> best_valid pulses twice; the second group's minimum is independent of the first.
- rst_n asserted with 6 entries in flight -> no out_valid and no best_valid after release; the next single candidate reports normally.

Source files
------------

// File: rtl/tree_adder_ctrl.sv
// Sequencer and flow controller for the 256-input, 8-stage pipelined signed tree adder.
// Optional performance counters are built when TREE_CTRL_PERF_EN is defined.
module tree_adder_ctrl #(
    parameter int LATENCY = 8,
    parameter int SUM_W   = 17,
    parameter int TAG_W   = 8
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic                    in_valid,
    output logic                    in_ready,
    input  logic [TAG_W-1:0]        in_tag,
    input  logic                    in_last,
    output logic                    adder_enable,
    input  logic signed [SUM_W-1:0] adder_sum,
    output logic                    out_valid,
    input  logic                    out_ready,
    output logic signed [SUM_W-1:0] out_sum,
    output logic [TAG_W-1:0]        out_tag,
    output logic                    out_last,
    output logic                    best_valid,
    output logic signed [SUM_W-1:0] best_sum,
    output logic [TAG_W-1:0]        best_tag,
    output logic                    busy
`ifdef TREE_CTRL_PERF_EN
    ,
    output logic [31:0]             perf_stall_cnt,
    output logic [31:0]             perf_bubble_cnt,
    output logic [15:0]             perf_group_cnt
`endif
);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_ACCUM = 2'd1,
        S_DONE  = 2'd2
    } state_t;

    logic [LATENCY-1:0]     r_vld;
    logic [LATENCY-1:0]     r_last;
    logic [TAG_W-1:0]       r_tag [LATENCY];
    state_t                 r_state;
    state_t                 w_state_nxt;
    logic signed [SUM_W-1:0] r_best_sum;
    logic [TAG_W-1:0]       r_best_tag;
    logic                   w_stall;
    logic                   w_enable;
    logic                   w_hs;
    logic                   w_load;

    // The whole pipeline, adder included, freezes only when the final stage cannot drain.
    assign w_stall      = r_vld[LATENCY-1] & ~out_ready;
    assign w_enable     = ~w_stall;
    assign w_hs         = r_vld[LATENCY-1] & out_ready;
    assign adder_enable = w_enable;
    assign in_ready     = w_enable;

    assign out_valid  = r_vld[LATENCY-1];
    assign out_tag    = r_tag[LATENCY-1];
    assign out_last   = r_last[LATENCY-1];
    assign out_sum    = adder_sum;
    assign busy       = |r_vld;
    assign best_valid = (r_state == S_DONE);
    assign best_sum   = r_best_sum;
    assign best_tag   = r_best_tag;

    // Valid/tag/last side-band shift register aligned with the adder stages.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_vld  <= '0;
            r_last <= '0;
            for (int k = 0; k < LATENCY; k++) begin
                r_tag[k] <= '0;
            end
        end else if (w_enable) begin
            r_vld  <= {r_vld[LATENCY-2:0], in_valid};
            r_last <= {r_last[LATENCY-2:0], in_last};
            r_tag[0] <= in_tag;
            for (int k = 1; k < LATENCY; k++) begin
                r_tag[k] <= r_tag[k-1];
            end
        end
    end

    // Group-minimum state register and best candidate capture.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state    <= S_IDLE;
            r_best_sum <= '0;
            r_best_tag <= '0;
        end else begin
            r_state <= w_state_nxt;
            if (w_load) begin
                r_best_sum <= out_sum;
                r_best_tag <= out_tag;
            end
        end
    end

    // Next state; a handshake in DONE opens the next group on the same edge.
    always_comb begin
        w_state_nxt = r_state;
        w_load      = 1'b0;
        case (r_state)
            S_IDLE, S_DONE: begin
                if (w_hs) begin
                    w_load      = 1'b1;
                    w_state_nxt = out_last ? S_DONE : S_ACCUM;
                end else begin
                    w_state_nxt = S_IDLE;
                end
            end
            S_ACCUM: begin
                if (w_hs) begin
                    // Strict compare: ties keep the earlier candidate.
                    w_load      = (out_sum < r_best_sum);
                    w_state_nxt = out_last ? S_DONE : S_ACCUM;
                end else begin
                    w_state_nxt = S_ACCUM;
                end
            end
            default: begin
                w_state_nxt = S_IDLE;
            end
        endcase
    end

`ifdef TREE_CTRL_PERF_EN
    logic [31:0] r_stall_cnt;
    logic [31:0] r_bubble_cnt;
    logic [15:0] r_group_cnt;

    assign perf_stall_cnt  = r_stall_cnt;
    assign perf_bubble_cnt = r_bubble_cnt;
    assign perf_group_cnt  = r_group_cnt;

    // Free-running wrap-around event counters.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_stall_cnt  <= 32'd0;
            r_bubble_cnt <= 32'd0;
            r_group_cnt  <= 16'd0;
        end else begin
            if (w_stall) begin
                r_stall_cnt <= r_stall_cnt + 32'd1;
            end
            if (w_enable && !in_valid && busy) begin
                r_bubble_cnt <= r_bubble_cnt + 32'd1;
            end
            if (r_state == S_DONE) begin
                r_group_cnt <= r_group_cnt + 16'd1;
            end
        end
    end
`endif

endmodule

// File: tb/tb_tree_adder_ctrl.sv
// Self-checking bench for tree_adder_ctrl: transaction-level model (per-entry enabled-edge ages
// and a running group minimum) checked every cycle, plus directed literal checks.
module tb_tree_adder_ctrl;

    localparam int LAT = 8;

    logic               clk = 1'b0;
    logic               rst_n = 1'b0;
    logic               in_valid = 1'b0;
    logic               in_ready;
    logic [7:0]         in_tag = 8'd0;
    logic               in_last = 1'b0;
    logic               adder_enable;
    logic signed [16:0] adder_sum;
    logic               out_valid;
    logic               out_ready = 1'b1;
    logic signed [16:0] out_sum;
    logic [7:0]         out_tag;
    logic               out_last;
    logic               best_valid;
    logic signed [16:0] best_sum;
    logic [7:0]         best_tag;
    logic               busy;
    logic signed [16:0] in_sum_drv = 17'sd0;

    tree_adder_ctrl #(.LATENCY(LAT), .SUM_W(17), .TAG_W(8)) dut (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
        .in_tag(in_tag), .in_last(in_last), .adder_enable(adder_enable),
        .adder_sum(adder_sum), .out_valid(out_valid), .out_ready(out_ready),
        .out_sum(out_sum), .out_tag(out_tag), .out_last(out_last),
        .best_valid(best_valid), .best_sum(best_sum), .best_tag(best_tag),
        .busy(busy)
    );

    always #5 clk = ~clk;

    // Stand-in for the tree adder: the candidate's total sum rides an enabled 8-deep pipe.
    logic signed [16:0] apipe [LAT];
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int k = 0; k < LAT; k++) apipe[k] <= 17'sd0;
        end else if (adder_enable) begin
            apipe[0] <= in_sum_drv;
            for (int k = 1; k < LAT; k++) apipe[k] <= apipe[k-1];
        end
    end
    assign adder_sum = apipe[LAT-1];

    typedef struct {
        logic signed [16:0] s;
        logic [7:0]         t;
        logic               l;
        int                 age;
    } ent_t;

    ent_t               q[$];
    logic               m_pulse = 1'b0;
    logic               m_in_grp = 1'b0;
    logic signed [16:0] m_best_s = 17'sd0;
    logic [7:0]         m_best_t = 8'd0;

    int total = 0;
    int bad = 0;
    int obs_pulses = 0;
    int obs_stalls = 0;
    int obs_hs = 0;
    int obs_ovcnt = 0;
    logic               obs_ov = 1'b0;
    logic signed [16:0] obs_sum = 17'sd0;
    logic [7:0]         obs_tag = 8'd0;
    logic signed [16:0] obs_bs = 17'sd0;
    logic [7:0]         obs_bt = 8'd0;

    task automatic cmp(input string nm, input logic signed [63:0] act, input logic signed [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0d expected %0d at %0t", nm, act, exp, $time);
        end
    endtask

    // Compare every DUT output against the model for the current cycle.
    task automatic check();
        logic ev;
        ev = (q.size() > 0) && (q[0].age >= LAT);
        cmp("in_ready", in_ready, !(ev && !out_ready));
        cmp("adder_enable", adder_enable, !(ev && !out_ready));
        cmp("out_valid", out_valid, ev);
        cmp("busy", busy, q.size() > 0);
        cmp("best_valid", best_valid, m_pulse);
        cmp("best_sum", best_sum, m_best_s);
        cmp("best_tag", best_tag, m_best_t);
        if (ev) begin
            cmp("out_sum", out_sum, q[0].s);
            cmp("out_tag", out_tag, q[0].t);
            cmp("out_last", out_last, q[0].l);
        end
        obs_ov  = out_valid;
        obs_sum = out_sum;
        obs_tag = out_tag;
        if (out_valid) obs_ovcnt++;
        if (out_valid && out_ready) obs_hs++;
        if (!in_ready) obs_stalls++;
        if (best_valid) begin
            obs_pulses++;
            obs_bs = best_sum;
            obs_bt = best_tag;
        end
    endtask

    // Advance the transaction model by one clock edge.
    task automatic model_step();
        logic ev, en, hs;
        ent_t e;
        ev = (q.size() > 0) && (q[0].age >= LAT);
        en = !(ev && !out_ready);
        hs = ev && out_ready;
        m_pulse = 1'b0;
        if (hs) begin
            e = q.pop_front();
            if (!m_in_grp || (e.s < m_best_s)) begin
                m_best_s = e.s;
                m_best_t = e.t;
            end
            m_in_grp = !e.l;
            if (e.l) m_pulse = 1'b1;
        end
        if (en) begin
            foreach (q[i]) q[i].age++;
            if (in_valid) q.push_back('{in_sum_drv, in_tag, in_last, 1});
        end
    endtask

    task automatic cyc(input logic v, input logic [7:0] t, input logic l,
                       input logic signed [16:0] s, input logic ordy);
        in_valid = v; in_tag = t; in_last = l; in_sum_drv = s; out_ready = ordy;
        #1;
        check();
        @(posedge clk);
        if (rst_n) model_step();
        @(negedge clk);
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        q.delete();
        m_pulse = 1'b0; m_in_grp = 1'b0; m_best_s = 17'sd0; m_best_t = 8'd0;
        #1;
        check();
        repeat (3) cyc(1'b0, 8'd0, 1'b0, 17'sd0, 1'b1);
        rst_n = 1'b1;
    endtask

    task automatic idle(input int n);
        repeat (n) cyc(1'b0, 8'd0, 1'b0, 17'sd0, 1'b1);
    endtask

    initial begin
        int n, p0;
        logic signed [16:0] sums4 [4];
        logic signed [16:0] rs;
        sums4[0] = 17'sd768; sums4[1] = -17'sd512; sums4[2] = -17'sd512; sums4[3] = 17'sd1792;

        do_reset();
        idle(20);

        // Single candidate: all operands 1 -> sum 256, tag 0x05.
        p0 = obs_pulses;
        cyc(1'b1, 8'h05, 1'b1, 17'sd256, 1'b1);
        n = 0;
        for (int k = 1; k <= 20; k++) begin
            cyc(1'b0, 8'd0, 1'b0, 17'sd0, 1'b1);
            n = k;
            if (obs_ov) break;
        end
        cmp("t2_latency", n, 8);
        cmp("t2_out_sum", obs_sum, 256);
        cmp("t2_out_tag", obs_tag, 5);
        idle(4);
        cmp("t2_pulses", obs_pulses - p0, 1);
        cmp("t2_best_sum", obs_bs, 256);
        cmp("t2_best_tag", obs_bt, 5);

        // Group of four with a tie at the minimum.
        p0 = obs_pulses;
        n = obs_hs;
        for (int i = 0; i < 4; i++) cyc(1'b1, 8'(i), i == 3, sums4[i], 1'b1);
        idle(14);
        cmp("t3_handshakes", obs_hs - n, 4);
        cmp("t3_pulses", obs_pulses - p0, 1);
        cmp("t3_best_sum", obs_bs, -512);
        cmp("t3_best_tag", obs_bt, 1);

        // Eight in flight, downstream stalls five cycles.
        for (int i = 0; i < 8; i++) cyc(1'b1, 8'(8'h20 + i), i == 7, 17'(100 * i - 300), 1'b0);
        obs_stalls = 0;
        repeat (5) cyc(1'b0, 8'd0, 1'b0, 17'sd0, 1'b0);
        cmp("t4_stall_cycles", obs_stalls, 5);
        n = obs_hs;
        idle(12);
        cmp("t4_handshakes", obs_hs - n, 8);

        // Two back-to-back groups, last on tags 3 and 7.
        p0 = obs_pulses;
        for (int i = 0; i < 8; i++) cyc(1'b1, 8'(i), (i == 3) || (i == 7), 17'(i * 37 - 120), 1'b1);
        idle(14);
        cmp("t5_pulses", obs_pulses - p0, 2);
        cmp("t5_best_sum", obs_bs, 4 * 37 - 120);
        cmp("t5_best_tag", obs_bt, 4);

        // Reset with six entries in flight.
        for (int i = 0; i < 6; i++) cyc(1'b1, 8'(i), i == 5, 17'(i), 1'b1);
        do_reset();
        n = obs_ovcnt;
        p0 = obs_pulses;
        idle(20);
        cmp("t6_no_out", obs_ovcnt - n, 0);
        cmp("t6_no_best", obs_pulses - p0, 0);
        cmp("t6_busy_after", busy, 0);
        cyc(1'b1, 8'h9a, 1'b1, -17'sd77, 1'b1);
        idle(12);
        cmp("t6_pulses", obs_pulses - p0, 1);
        cmp("t6_best_sum", obs_bs, -77);
        cmp("t6_best_tag", obs_bt, 8'h9a);

        // Randomized traffic with random back-pressure and frequent ties.
        for (int i = 0; i < 3000; i++) begin
            if ($urandom_range(0, 2) == 0) rs = 17'($signed($urandom_range(0, 7)) - 4);
            else rs = 17'($signed($urandom_range(0, 65535)) - 32768);
            cyc($urandom_range(0, 3) != 0, 8'($urandom_range(0, 255)),
                $urandom_range(0, 3) == 0, rs, $urandom_range(0, 9) < 7);
        end
        idle(20);
        cmp("drain_busy", busy, 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
